// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
//
// Purpose:
//   Shared constants and helpers for the four-digit multiplexed 7-segment
//   display driver (seg7_scan4) and its BCD decoder (seg7_dec).
//
// Segment bit order (applies to every 7-bit segment vector in this slice):
//   bit 6 .. bit 0  =  g f e d c b a, active-low (0 = segment lit).
//
// Contents:
//   NUM_DIGITS     number of multiplexed digits
//   seg_t          7-bit active-low segment vector
//   SEG_0..SEG_9   glyphs for decimal digits 0..9
//   SEG_BLANK      all segments off
//   BCD_BLANK      BCD code that decodes to SEG_BLANK (used to force a blank)
//   an_onehot_low  anode pattern for a given digit index
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg_t;

    //                             gfedcba
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Any code 10..15 decodes blank; 15 is the one used to force a blank.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Active-low anode enable for digit idx: a single zero at position idx.
    function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
        logic [3:0] w_onehot;
        w_onehot = 4'b0001 << idx;
        return ~w_onehot;
    endfunction

endpackage : seg7_pkg

// File: rtl/seg7_dec.sv
// ----------------------------------------------------------------------------
// seg7_dec
//
// Purpose:
//   Combinational BCD to 7-segment decoder, active-low outputs.
//   Codes 0..9 give the standard glyphs; codes 10..15 give a blank digit.
//
// Ports:
//   i_bcd    [3:0]  BCD digit
//   o_seg_n  [6:0]  segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_n = SEG_0;
            4'd1:    o_seg_n = SEG_1;
            4'd2:    o_seg_n = SEG_2;
            4'd3:    o_seg_n = SEG_3;
            4'd4:    o_seg_n = SEG_4;
            4'd5:    o_seg_n = SEG_5;
            4'd6:    o_seg_n = SEG_6;
            4'd7:    o_seg_n = SEG_7;
            4'd8:    o_seg_n = SEG_8;
            4'd9:    o_seg_n = SEG_9;
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule : seg7_dec

// File: rtl/seg7_scan4.sv
// ----------------------------------------------------------------------------
// seg7_scan4
//
// Purpose:
//   Four-digit multiplexed common-anode 7-segment display driver. A free
//   running prescaler divides time into slots of 2^PRESCALE_W clocks; each
//   slot lights one digit, four slots make a frame. New values are captured
//   into a shadow register on i_load and only copied into the display
//   register at the frame boundary, so a frame never mixes old and new
//   digits. The first BLANK_CYC clocks of every slot keep all anodes off to
//   suppress ghosting while the segment lines settle.
//
// Configuration:
//   SEG7_LZB_EN  when defined, leading zeros are blanked (digits 3..1 are
//                blank while they and every higher digit are zero; digit 0
//                is always shown; decimal points are still honoured and the
//                anode is still driven for a blanked digit).
//
// Parameters:
//   PRESCALE_W   prescaler width; slot length = 2^PRESCALE_W clocks
//   BLANK_CYC    all-anodes-off clocks at the start of each slot,
//                0 .. 2^PRESCALE_W-2
//
// Ports:
//   i_clk / clk        system clock (port name clk)
//   rst_n              asynchronous active-low reset
//   bcd_in     [15:0]  digits {d3,d2,d1,d0}, d3 most significant
//   dp_in      [3:0]   decimal point per digit, 1 = lit
//   load               capture bcd_in/dp_in into the shadow register
//   an_n       [3:0]   digit enables, active-low
//   seg_n      [6:0]   segments {g,f,e,d,c,b,a}, active-low
//   dp_n               decimal point, active-low
//   frame_done         one-cycle pulse after the display register updates
//
// All outputs are registered and reflect the prescaler, digit index and
// display register of the previous cycle.
// ----------------------------------------------------------------------------
module seg7_scan4
    import seg7_pkg::*;
#(
    parameter int PRESCALE_W = 13,
    parameter int BLANK_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int                    BCD_W   = NUM_DIGITS * 4;
    localparam logic [PRESCALE_W-1:0] BLANK_P = PRESCALE_W'(BLANK_CYC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_p;
    logic [1:0]            r_idx;
    logic [BCD_W-1:0]      r_shadow_bcd;
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [BCD_W-1:0]      r_disp_bcd;
    logic [NUM_DIGITS-1:0] r_disp_dp;

    logic [3:0]            r_an_n;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic                  r_frame_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_tc;
    logic                  w_frame_end;
    logic                  w_blank_win;
    logic [3:0]            w_digit;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic [3:0]            w_dec_in;
    logic [6:0]            w_dec_seg_n;

    assign w_tc        = &r_p;
    assign w_frame_end = w_tc && (r_idx == 2'd3);

    // A zero-length blank window must not produce an always-false compare.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_blank_win = 1'b0;
        end else begin : g_blank
            assign w_blank_win = (r_p < BLANK_P);
        end
    endgenerate

    assign w_digit = r_disp_bcd[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    // Leading-zero flags: a digit is blanked only if every digit above it
    // is also zero, so an interior zero (e.g. 1 0 5) is always shown.
    logic [NUM_DIGITS-1:0] w_is_zero;

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_is_zero[k] = (r_disp_bcd[k*4 +: 4] == 4'd0);
        end
        w_lz_blank    = '0;
        w_lz_blank[3] = w_is_zero[3];
        w_lz_blank[2] = w_is_zero[3] & w_is_zero[2];
        w_lz_blank[1] = w_is_zero[3] & w_is_zero[2] & w_is_zero[1];
        w_lz_blank[0] = 1'b0;
    end
`else
    assign w_lz_blank = '0;
`endif

    // A forced blank is routed through the decoder as an out-of-range code.
    assign w_dec_in = w_lz_blank[r_idx] ? BCD_BLANK : w_digit;

    seg7_dec u_dec (
        .i_bcd   (w_dec_in),
        .o_seg_n (w_dec_seg_n)
    );

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_idx <= 2'd0;
        end else begin
            r_p <= r_p + 1'b1;
            if (w_tc) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow register: tracks every load.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
        end else if (load) begin
            r_shadow_bcd <= bcd_in;
            r_shadow_dp  <= dp_in;
        end
    end

    // ------------------------------------------------------------------
    // Display register: only changes at the frame boundary. A load landing
    // on the boundary cycle bypasses the shadow so it is not delayed a
    // whole frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_bcd <= '0;
            r_disp_dp  <= '0;
        end else if (w_frame_end) begin
            if (load) begin
                r_disp_bcd <= bcd_in;
                r_disp_dp  <= dp_in;
            end else begin
                r_disp_bcd <= r_shadow_bcd;
                r_disp_dp  <= r_shadow_dp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n       <= 4'hF;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_blank_win) begin
                r_an_n  <= 4'hF;
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end else begin
                r_an_n  <= an_onehot_low(r_idx);
                r_seg_n <= w_dec_seg_n;
                r_dp_n  <= ~r_disp_dp[r_idx];
            end
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_done = r_frame_done;

endmodule : seg7_scan4

// File: tb/tb_seg7_scan4.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan4
//
// Two instances share clock, reset and inputs:
//   dut_b : PRESCALE_W=4, BLANK_CYC=2 (16-clock slots, 2-clock gap)
//   dut_z : PRESCALE_W=4, BLANK_CYC=0 (no gap)
// n counts rising edges since reset release; the state after edge n is
// p = n%16, idx = (n/16)%4, and outputs sampled after edge n reflect the
// state after edge n-1.
// ----------------------------------------------------------------------------
module tb_seg7_scan4;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;

    logic [3:0]  an_n_b,  an_n_z;
    logic [6:0]  seg_n_b, seg_n_z;
    logic        dp_n_b,  dp_n_z;
    logic        fd_b,    fd_z;

    int n;
    int tests;
    int failed;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] EXP_HI_ZERO = 7'h7F;
`else
    localparam logic [6:0] EXP_HI_ZERO = 7'h40;
`endif

    seg7_scan4 #(.PRESCALE_W(4), .BLANK_CYC(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .an_n       (an_n_b),
        .seg_n      (seg_n_b),
        .dp_n       (dp_n_b),
        .frame_done (fd_b)
    );

    seg7_scan4 #(.PRESCALE_W(4), .BLANK_CYC(0)) dut_z (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .an_n       (an_n_z),
        .seg_n      (seg_n_z),
        .dp_n       (dp_n_z),
        .frame_done (fd_z)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } vec_t;

    vec_t tbl[$];
    vec_t tbl2[$];

    function automatic vec_t mk(input int vn, input logic [3:0] van,
                                input logic [6:0] vseg, input logic vdp,
                                input logic vfd);
        vec_t v;
        v.n = vn; v.an = van; v.seg = vseg; v.dp = vdp; v.fd = vfd;
        return v;
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s n=%0d actual=%h required=%h", nm, n, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t v);
        chk("tbl_an",  16'(an_n_b),  16'(v.an));
        chk("tbl_seg", 16'(seg_n_b), 16'(v.seg));
        chk("tbl_dp",  16'(dp_n_b),  16'(v.dp));
        chk("tbl_fd",  16'(fd_b),    16'(v.fd));
    endtask

    // One rising edge, then per-cycle checks at the following falling edge.
    task automatic step();
        int         slot;
        logic [3:0] e_an_z;
        logic [3:0] e_an_b;
        @(posedge clk);
        n++;
        @(negedge clk);
        slot   = ((n - 1) / 16) % 4;
        e_an_z = ~(4'b0001 << slot);
        e_an_b = (((n - 1) % 16) >= 2) ? e_an_z : 4'hF;
        chk("scan_an_b", 16'(an_n_b), 16'(e_an_b));
        chk("scan_an_z", 16'(an_n_z), 16'(e_an_z));
        chk("frame_done_b", 16'(fd_b), 16'((n >= 64) && (n % 64 == 0)));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an_b"},  16'(an_n_b),  16'h000F);
        chk({tag, "_seg_b"}, 16'(seg_n_b), 16'h007F);
        chk({tag, "_dp_b"},  16'(dp_n_b),  16'h0001);
        chk({tag, "_fd_b"},  16'(fd_b),    16'h0000);
        chk({tag, "_an_z"},  16'(an_n_z),  16'h000F);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        tests  = 0;
        failed = 0;
        n      = 0;
        rst_n  = 1'b0;
        bcd_in = 16'h0000;
        dp_in  = 4'h0;
        load   = 1'b0;

        // Frames 0..3 of the main run.
        tbl.push_back(mk(  1, 4'hF, 7'h7F, 1'b1, 1'b0));
        tbl.push_back(mk(  2, 4'hF, 7'h7F, 1'b1, 1'b0));
        tbl.push_back(mk(  3, 4'hE, 7'h40, 1'b1, 1'b0));
        tbl.push_back(mk( 16, 4'hE, 7'h40, 1'b1, 1'b0));
        tbl.push_back(mk( 17, 4'hF, 7'h7F, 1'b1, 1'b0));
        tbl.push_back(mk( 18, 4'hF, 7'h7F, 1'b1, 1'b0));
        tbl.push_back(mk( 19, 4'hD, 7'h40, 1'b1, 1'b0));
        tbl.push_back(mk( 35, 4'hB, 7'h40, 1'b1, 1'b0)); // 1234 loaded, not shown yet
        tbl.push_back(mk( 51, 4'h7, 7'h40, 1'b1, 1'b0));
        tbl.push_back(mk( 63, 4'h7, 7'h40, 1'b1, 1'b0));
        tbl.push_back(mk( 64, 4'h7, 7'h40, 1'b1, 1'b1));
        tbl.push_back(mk( 65, 4'hF, 7'h7F, 1'b1, 1'b0));
        tbl.push_back(mk( 67, 4'hE, 7'h19, 1'b1, 1'b0)); // 4
        tbl.push_back(mk( 83, 4'hD, 7'h30, 1'b1, 1'b0)); // 3
        tbl.push_back(mk( 99, 4'hB, 7'h24, 1'b1, 1'b0)); // 2
        tbl.push_back(mk(115, 4'h7, 7'h79, 1'b1, 1'b0)); // 1
        tbl.push_back(mk(128, 4'h7, 7'h79, 1'b1, 1'b1));
        tbl.push_back(mk(131, 4'hE, 7'h00, 1'b1, 1'b0)); // 8 via bypass
        tbl.push_back(mk(147, 4'hD, 7'h78, 1'b1, 1'b0)); // 7
        tbl.push_back(mk(163, 4'hB, 7'h02, 1'b1, 1'b0)); // 6
        tbl.push_back(mk(179, 4'h7, 7'h12, 1'b1, 1'b0)); // 5
        tbl.push_back(mk(192, 4'h7, 7'h12, 1'b1, 1'b1));
        tbl.push_back(mk(195, 4'hE, 7'h78, 1'b1, 1'b0)); // 7
        tbl.push_back(mk(209, 4'hF, 7'h7F, 1'b1, 1'b0)); // gap hides dp
        tbl.push_back(mk(211, 4'hD, 7'h7F, 1'b0, 1'b0)); // A blank, dp lit
        tbl.push_back(mk(227, 4'hB, EXP_HI_ZERO, 1'b1, 1'b0));
        tbl.push_back(mk(230, 4'hB, EXP_HI_ZERO, 1'b1, 1'b0));

        // After the mid-slot reset.
        tbl2.push_back(mk( 1, 4'hF, 7'h7F, 1'b1, 1'b0));
        tbl2.push_back(mk( 3, 4'hE, 7'h40, 1'b1, 1'b0));
        tbl2.push_back(mk(19, 4'hD, 7'h40, 1'b1, 1'b0));

        // Reset state.
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Main run: loads at mid-frame, on the boundary, and mid-frame again.
        k = 0;
        while (n < 230) begin
            step();
            if (k < tbl.size() && tbl[k].n == n) begin
                chk_vec(tbl[k]);
                k++;
            end
            case (n)
                20:  begin load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000; end
                127: begin load = 1'b1; bcd_in = 16'h5678; dp_in = 4'b0000; end
                150: begin load = 1'b1; bcd_in = 16'h00A7; dp_in = 4'b0010; end
                default: load = 1'b0;
            endcase
        end
        chk("tbl_consumed", 16'(k), 16'(tbl.size()));

        // Reset mid-slot at idx=2: outputs clear before any clock edge.
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        n     = 0;

        k = 0;
        while (n < 20) begin
            step();
            if (k < tbl2.size() && tbl2[k].n == n) begin
                chk_vec(tbl2[k]);
                k++;
            end
        end
        chk("tbl2_consumed", 16'(k), 16'(tbl2.size()));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_seg7_scan4
